// File: rtl/panic_rx_parse_mux.sv
// Ingress parser/mux: round-robin, packet-atomic selection of one AXI-stream port onto m_axis,
// with per-packet descriptor {port, len, flow, time} queued in a small FIFO.
module panic_rx_parse_mux #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned DESC_DEPTH   = 16,
  parameter int unsigned FLOW_OFFSET  = 26,
  parameter int unsigned FLOW_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned TIME_WIDTH   = 16,
  parameter int unsigned DROP_ON_FULL = 0,
  localparam int unsigned PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned DESC_W      = PORT_W + LEN_WIDTH + FLOW_WIDTH + TIME_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [DESC_W-1:0]               m_desc,
  output logic                            m_desc_valid,
  input  logic                            m_desc_ready,
  output logic [31:0]                     drop_count
);

  localparam int unsigned AW    = $clog2(DESC_DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

  state_e                r_state;
  logic [PORT_W-1:0]     r_sel, r_last_grant;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_in_pkt;
  logic [FLOW_WIDTH-1:0] r_flow;
  logic [TIME_WIDTH-1:0] r_time, r_tstamp;
  logic [31:0]           r_drop_count;

  logic [DESC_W-1:0]     r_mem [DESC_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [KEEP_WIDTH-1:0] w_sel_keep;
  logic                  w_sel_valid, w_sel_last, w_sel_ready, w_accept;
  logic                  w_req_any, w_found;
  logic [PORT_W-1:0]     w_grant;
  logic [LEN_WIDTH:0]    w_popcnt, w_len_sum;
  logic [LEN_WIDTH-1:0]  w_len_next;
  logic [FLOW_WIDTH-1:0] w_flow_now, w_flow;
  logic [TIME_WIDTH-1:0] w_time;
  logic                  w_full, w_push, w_pop;
  logic [DESC_W-1:0]     w_desc_in;

  assign w_sel_data  = s_axis_tdata[int'(r_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_keep  = s_axis_tkeep[int'(r_sel)*KEEP_WIDTH +: KEEP_WIDTH];
  assign w_sel_valid = s_axis_tvalid[r_sel];
  assign w_sel_last  = s_axis_tlast[r_sel];
  assign w_sel_ready = ((r_state == StFwd) && m_axis_tready) || (r_state == StDrop);
  assign w_accept    = w_sel_valid && w_sel_ready;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    logic [NUM_PORTS-1:0] rot;
    int unsigned          idx;
    w_req_any = |s_axis_tvalid;
    w_found   = 1'b0;
    w_grant   = r_last_grant;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_PORTS;
      rot = s_axis_tvalid >> idx;
      if (!w_found && rot[0]) begin
        w_found = 1'b1;
        w_grant = PORT_W'(idx);
      end
    end
  end

  always_comb begin
    w_popcnt = '0;
    for (int unsigned b = 0; b < KEEP_WIDTH; b++) begin
      w_popcnt = w_popcnt + (LEN_WIDTH + 1)'(w_sel_keep[b]);
    end
    w_len_sum  = {1'b0, r_len} + w_popcnt;
    w_len_next = w_len_sum[LEN_WIDTH] ? '1 : w_len_sum[LEN_WIDTH-1:0];
  end

  // A single-beat packet takes flow/time straight from the current beat.
  assign w_flow_now = w_sel_data[FLOW_OFFSET*8 +: FLOW_WIDTH];
  assign w_flow     = r_in_pkt ? r_flow : w_flow_now;
  assign w_time     = r_in_pkt ? r_time : r_tstamp;
  assign w_desc_in  = {r_sel, w_len_next, w_flow, w_time};

  assign w_full = (r_count == CNT_W'(DESC_DEPTH));
  assign w_push = (r_state == StFwd) && w_accept && w_sel_last;
  assign w_pop  = (r_count != '0) && m_desc_ready;

  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = w_sel_data;
    m_axis_tkeep  = w_sel_keep;
    m_axis_tlast  = w_sel_last;
    m_axis_tvalid = 1'b0;
    case (r_state)
      StFwd: begin
        m_axis_tvalid        = w_sel_valid;
        s_axis_tready[r_sel] = m_axis_tready;
      end
      StDrop:  s_axis_tready[r_sel] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_sel        <= '0;
      r_last_grant <= PORT_W'(NUM_PORTS - 1);
      r_len        <= '0;
      r_in_pkt     <= 1'b0;
      r_flow       <= '0;
      r_time       <= '0;
      r_tstamp     <= '0;
      r_drop_count <= '0;
    end else begin
      r_tstamp <= r_tstamp + TIME_WIDTH'(1);
      case (r_state)
        StIdle: begin
          if (w_req_any && !w_full) begin
            r_sel   <= w_grant;
            r_state <= StFwd;
          end else if (w_req_any && (DROP_ON_FULL != 0)) begin
            r_sel   <= w_grant;
            r_state <= StDrop;
          end
        end
        StFwd, StDrop: begin
          if (w_accept) begin
            r_len <= w_len_next;
            if (!r_in_pkt) begin
              r_in_pkt <= 1'b1;
              r_flow   <= w_flow_now;
              r_time   <= r_tstamp;
            end
            if (w_sel_last) begin
              r_state      <= StIdle;
              r_last_grant <= r_sel;
              r_len        <= '0;
              r_in_pkt     <= 1'b0;
              if ((r_state == StDrop) && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 32'd1;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_desc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign m_desc       = r_mem[r_rd_ptr];
  assign m_desc_valid = (r_count != '0);
  assign drop_count   = r_drop_count;

endmodule
